// File: rtl/dc_delay_line.sv
// dc_delay_line
//   Enable-gated WIDTH x DEPTH register delay line for the DC-elimination path.
//   A sample accepted on a strobe (en=1, clr=0) reaches q after DEPTH strobes.
//   The line tracks how many genuine samples it holds and pulses q_valid when
//   q has just been loaded with one. clr flushes synchronously and wins over en.
//
//   Optional feature macro: DC_DELAY_LINE_RUNNING_SUM_EN
//     When defined, adds port sum = signed sum of all stage contents. The sum is
//     kept over the same DEPTH-sample window, so it serves as a DC estimate.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   en        in   sample strobe
//   clr       in   synchronous flush (priority over en)
//   d         in   [WIDTH-1:0] input sample (two's complement)
//   q         out  [WIDTH-1:0] oldest stage (registered)
//   q_valid   out  single-cycle pulse: q holds a genuine sample just loaded
//   full      out  all DEPTH stages hold genuine samples
//   fill_cnt  out  [CW-1:0] genuine samples in the line, saturates at DEPTH
//   sum       out  [SW-1:0] signed window sum (only with the macro)
module dc_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int SW = WIDTH + $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     d,
  output logic [WIDTH-1:0]     q,
  output logic                 q_valid,
  output logic                 full,
`ifdef DC_DELAY_LINE_RUNNING_SUM_EN
  output logic signed [SW-1:0] sum,
`endif
  output logic [CW-1:0]        fill_cnt
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  // One bit wider so the "about to become full" test is never a constant compare.
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [CW-1:0]    fill_cnt_q, fill_cnt_d;
  logic             full_q, full_d;
  logic             q_valid_q, q_valid_d;
  logic [CW:0]      fill_next_w;

`ifdef DC_DELAY_LINE_RUNNING_SUM_EN
  logic signed [SW-1:0] sum_q, sum_d;
`endif

  // Next-state logic: flush, shift on strobe, or hold.
  always_comb begin
    stage_d     = stage_q;
    fill_cnt_d  = fill_cnt_q;
    full_d      = full_q;
    q_valid_d   = 1'b0;
    fill_next_w = {1'b0, fill_cnt_q} + {{CW{1'b0}}, 1'b1};
`ifdef DC_DELAY_LINE_RUNNING_SUM_EN
    sum_d       = sum_q;
`endif
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = {WIDTH{1'b0}};
      end
      fill_cnt_d = {CW{1'b0}};
      full_d     = 1'b0;
      q_valid_d  = 1'b0;
`ifdef DC_DELAY_LINE_RUNNING_SUM_EN
      sum_d      = {SW{1'b0}};
`endif
    end else if (en) begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
      if (fill_cnt_q < DEPTH_C) begin
        fill_cnt_d = fill_cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        fill_cnt_d = fill_cnt_q;
      end
      full_d = (fill_cnt_d == DEPTH_C);
      // Pre-edge fill >= DEPTH-1 means the sample landing in the last stage is genuine.
      q_valid_d = (fill_next_w >= DEPTH_W);
`ifdef DC_DELAY_LINE_RUNNING_SUM_EN
      // Add the incoming sample, drop the one falling off the end; stays exact at SW bits.
      sum_d = sum_q + SW'($signed(d)) - SW'($signed(stage_q[DEPTH-1]));
`endif
    end else begin
      q_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= {WIDTH{1'b0}};
      end
      fill_cnt_q <= {CW{1'b0}};
      full_q     <= 1'b0;
      q_valid_q  <= 1'b0;
`ifdef DC_DELAY_LINE_RUNNING_SUM_EN
      sum_q      <= {SW{1'b0}};
`endif
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
      fill_cnt_q <= fill_cnt_d;
      full_q     <= full_d;
      q_valid_q  <= q_valid_d;
`ifdef DC_DELAY_LINE_RUNNING_SUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign q        = stage_q[DEPTH-1];
  assign q_valid  = q_valid_q;
  assign full     = full_q;
  assign fill_cnt = fill_cnt_q;
`ifdef DC_DELAY_LINE_RUNNING_SUM_EN
  assign sum      = sum_q;
`endif

endmodule

// File: doc/dc_delay_line.md
Name: dc_delay_line

Overview:
- Parametrised, enable-gated register delay line for the DC-elimination path. Generalises the fixed 32-bit single-stage register to WIDTH bits and DEPTH stages.
- Adds a sample strobe, a synchronous flush, fill tracking and an output-valid pulse.
- Used to delay raw samples by DEPTH strobes so they align with a DC estimate. The optional running sum provides that estimate over the same window.

Parameters:
- WIDTH, 32, sample width in bits; samples are two's complement.
- DEPTH, 1, number of delay stages; legal range 1..1024. DEPTH=1 gives a plain register with enable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample strobe; d is accepted on a clk edge where en=1.
- clr  input  1  synchronous flush; has priority over en.
- d  input  WIDTH  input sample.
- q  output  WIDTH  sample accepted exactly DEPTH strobes earlier (stage DEPTH-1), registered.
- q_valid  output  1  one-cycle pulse: q has just been loaded with a genuine sample.
- full  output  1  high when all DEPTH stages hold genuine samples.
- fill_cnt  output  CW=$clog2(DEPTH+1)  count of genuine samples in the line, saturating at DEPTH.
- sum  output  SW=WIDTH+$clog2(DEPTH)  signed sum of all stage contents; present only with RUNNING_SUM_EN.

Behaviour:
- Reset (rst=1, asynchronous):
  - all stages, q, q_valid, full, fill_cnt and sum go to 0 immediately;
  - held at 0 while rst is high;
  - first strobe is honoured on the first clk edge after rst deasserts.
- Shift, on a clk edge with clr=0 and en=1:
  - stage[0] <= d; stage[i] <= stage[i-1] for i=1..DEPTH-1;
  - q is stage[DEPTH-1].
- Latency: a sample accepted at strobe k appears on q after the edge of strobe k+DEPTH-1. With DEPTH=1, q = d one edge after the strobe.
- en=0, clr=0: all state holds; q_valid=0.
- fill_cnt:
  - increments by 1 on each accepted strobe while fill_cnt < DEPTH;
  - saturates at DEPTH with no wrap.
  - full = (fill_cnt == DEPTH), registered alongside fill_cnt.
- q_valid:
  - registered; = 1 for the single cycle following an accepted strobe whose pre-edge fill_cnt >= DEPTH-1;
  - otherwise 0;
  - never asserted while en is held low.
- Back-to-back strobes: legal every cycle; q_valid stays high continuously once the line is full.
- clr=1 on an edge:
  - stages, fill_cnt, full, q_valid and sum go to 0;
  - en on the same edge is ignored and the sample is dropped.
- Reset mid-operation: identical to clr but asynchronous; no partial state survives.
- Stage contents before fill are zeros, so q shows 0 until the first genuine sample arrives. q_valid is the only qualifier of genuine output.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DC_DELAY_LINE_RUNNING_SUM_EN.
- Defined:
  - port sum exists;
  - on each accepted strobe: sum <= sum + sext(d) - sext(stage[DEPTH-1]), computed at SW bits;
  - clr and rst zero it;
  - sum always equals the signed sum of the current stage contents, so it cannot overflow;
  - registered; updates on the same edge as the shift.
- Not defined: sum port and adder absent; all other behaviour identical.

Test Plan:
- WIDTH=32, DEPTH=1: rst pulse, then en=1 with d=0xDEADBEEF -> next cycle q=0xDEADBEEF, q_valid=1, full=1, fill_cnt=1. en=0 with d changed -> q holds, q_valid=0.
- WIDTH=16, DEPTH=4, strobes every cycle with d=1,2,3,4,5,6:
  - q_valid first high after the 4th strobe with q=1;
  - then q=2, 3;
  - fill_cnt goes 1,2,3,4,4,4.
- Same config, en pulsed every 3rd cycle with d=10,20,30,40,50:
  - q changes only after strobe edges; q=10 after strobe 4 and 20 after strobe 5;
  - q_valid is a single-cycle pulse after strobes 4 and 5 only.
- Full line, then clr=1 and en=1 on the same edge with d=99:
  - next cycle q=0, fill_cnt=0, full=0, q_valid=0;
  - 99 never appears on q.
- Async reset asserted between clock edges while full -> q and fill_cnt are 0 before the next clk edge.
- With DC_DELAY_LINE_RUNNING_SUM_EN, WIDTH=16, DEPTH=4:
  - d=-32768 x4 -> sum=-131072;
  - then d=32767 x4 -> sum=131068;
  - then clr -> sum=0.
